// File: rtl/rfft_seq_ctrl.sv
// rfft_seq_ctrl: frame load, butterfly issue/drain and done sequencing for the 4-bank RFFT.
// Define RFFT_CTRL_READOUT_EN to add a READOUT phase with out_valid/out_index.
module rfft_seq_ctrl #(
  parameter int ADDR_BIT = 3,
  parameter int N_STAGES = 3,
  parameter int RD_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    m0,
  output logic                    m11,
  output logic [1:0]              m12,
  output logic [1:0]              m13,
  output logic                    m14,
  output logic                    m21,
  output logic                    m22,
  output logic                    m23,
  output logic                    m24,
  output logic                    bypass_en,
  output logic                    wr_en,
  output logic [4*ADDR_BIT-1:0]   addr_read,
  output logic [4*ADDR_BIT-1:0]   addr_write,
  output logic [ADDR_BIT-1:0]     tw_addr,
  output logic [2:0]              stage
`ifdef RFFT_CTRL_READOUT_EN
  ,
  output logic                    out_valid,
  output logic [ADDR_BIT-1:0]     out_index
`endif
);

  localparam int DEPTH = 1 << ADDR_BIT;
  localparam logic [ADDR_BIT-1:0] K_LAST = ADDR_BIT'(DEPTH - 1);
  localparam logic [2:0] S_LAST = 3'(N_STAGES - 1);
  localparam logic [2:0] D_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_READ,
    S_RDRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                m0;
    logic                m11;
    logic [1:0]          m12;
    logic [1:0]          m13;
    logic                m14;
    logic                m21;
    logic                m22;
    logic                m23;
    logic                m24;
    logic [ADDR_BIT-1:0] addr;
    logic [ADDR_BIT-1:0] tw;
  } slot_t;

  state_t state, state_n;

  logic [ADDR_BIT-1:0] k;
  logic [ADDR_BIT-1:0] aw_q;
  logic [ADDR_BIT-1:0] tw_now;
  logic [2:0]          dcnt;
  logic                k_last;
  logic                d_last;
  logic                s_last;
  logic                issue;

  logic [RD_LAT-1:0]   pv;
  slot_t               pipe [RD_LAT];
  slot_t               issue_slot;
  slot_t               lst;
  logic                lv;

  assign k_last = (k == K_LAST);
  assign d_last = (dcnt == D_LAST);
  assign s_last = (stage == S_LAST);
  assign issue  = (state == S_ISSUE);
  assign tw_now = k << stage;
  assign lst    = pipe[RD_LAT-1];
  assign lv     = pv[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD:  if (in_valid && k_last) state_n = S_ISSUE;
      S_ISSUE: if (k_last) state_n = S_DRAIN;
      S_DRAIN: begin
        if (d_last) begin
          if (!s_last) begin
            state_n = S_ISSUE;
          end else begin
`ifdef RFFT_CTRL_READOUT_EN
            state_n = S_READ;
`else
            state_n = S_DONE;
`endif
          end
        end
      end
      S_READ:   if (k_last) state_n = S_RDRAIN;
      S_RDRAIN: if (d_last) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // k is the word/issue index; dcnt counts drain cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      aw_q  <= '0;
      dcnt  <= '0;
      stage <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          k    <= '0;
          dcnt <= '0;
          if (start) begin
            stage <= '0;
            aw_q  <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            k    <= k + 1'b1;
            aw_q <= k;
          end
        end
        S_ISSUE, S_READ: begin
          k    <= k + 1'b1;
          dcnt <= '0;
        end
        S_DRAIN: begin
          dcnt <= dcnt + 3'd1;
          if (d_last) begin
            dcnt <= '0;
            k    <= '0;
            if (!s_last) stage <= stage + 3'd1;
          end
        end
        S_RDRAIN: dcnt <= dcnt + 3'd1;
        S_DONE: begin
          k    <= '0;
          dcnt <= '0;
        end
        default: begin
          k    <= '0;
          dcnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    issue_slot      = '0;
    issue_slot.m0   = 1'b1;
    issue_slot.m23  = 1'b1;
    issue_slot.m24  = 1'b1;
    issue_slot.addr = k;
    issue_slot.tw   = tw_now;
    if (stage[0]) begin
      issue_slot.m11 = 1'b1;
      issue_slot.m13 = 2'd2;
    end else begin
      issue_slot.m12 = 2'd1;
      issue_slot.m13 = 2'd1;
      issue_slot.m14 = 1'b1;
    end
  end

  // Slot fields only advance behind a valid slot, so selects hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pv[0] <= issue;
      if (issue) pipe[0] <= issue_slot;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pipe[i] <= pipe[i-1];
      end
    end
  end

`ifdef RFFT_CTRL_READOUT_EN
  logic [RD_LAT-1:0]   rv;
  logic [ADDR_BIT-1:0] ridx [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      rv <= '0;
      for (int i = 0; i < RD_LAT; i++) ridx[i] <= '0;
    end else begin
      rv[0] <= (state == S_READ);
      if (state == S_READ) ridx[0] <= k;
      for (int i = 1; i < RD_LAT; i++) begin
        rv[i] <= rv[i-1];
        if (rv[i-1]) ridx[i] <= ridx[i-1];
      end
    end
  end

  assign out_valid = rv[RD_LAT-1];
  assign out_index = ridx[RD_LAT-1];
`endif

  always_comb begin
    in_ready   = 1'b0;
    busy       = (state != S_IDLE) && (state != S_DONE);
    done       = 1'b0;
    wr_en      = lv;
    m0         = lst.m0;
    m11        = lst.m11;
    m12        = lst.m12;
    m13        = lst.m13;
    m14        = lst.m14;
    m21        = lst.m21;
    m22        = lst.m22;
    m23        = lst.m23;
    m24        = lst.m24;
    bypass_en  = lv && (lst.tw == '0);
    addr_read  = '0;
    addr_write = {4{lst.addr}};
    tw_addr    = '0;
    unique case (state)
      S_LOAD: begin
        in_ready   = 1'b1;
        m0         = 1'b0;
        wr_en      = in_valid;
        addr_write = in_valid ? {4{k}} : {4{aw_q}};
      end
      S_ISSUE: begin
        addr_read = {4{k}};
        tw_addr   = tw_now;
      end
      S_READ:  addr_read = {4{k}};
      S_DONE:  done = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_rfft_seq_ctrl.sv
// Directed bench for rfft_seq_ctrl at ADDR_BIT=3, N_STAGES=3, RD_LAT=1.
// Load tables plus hand sequences for compute timing, abort and readout.
`timescale 1ns/1ps
module tb_rfft_seq_ctrl;
  localparam int NS   = 3;
  localparam int SPAN = 9;
`ifdef RFFT_CTRL_READOUT_EN
  localparam int DONE_AT = 36;
`else
  localparam int DONE_AT = 27;
`endif

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic in_ready, busy, done, m0;
  logic m11, m14, m21, m22, m23, m24;
  logic [1:0] m12, m13;
  logic bypass_en, wr_en;
  logic [11:0] addr_read, addr_write;
  logic [2:0] tw_addr, stage;
`ifdef RFFT_CTRL_READOUT_EN
  logic out_valid;
  logic [2:0] out_index;
`endif

  logic [63:0] outs;
  logic [9:0]  sel;
  assign outs = {18'd0, in_ready, busy, done, m0, m11, m12, m13, m14,
                 m21, m22, m23, m24, bypass_en, wr_en,
                 addr_read, addr_write, tw_addr, stage};
  assign sel = {m11, m12, m13, m14, m21, m22, m23, m24};

  always #5 clk = ~clk;

  rfft_seq_ctrl #(
    .ADDR_BIT(3),
    .N_STAGES(3),
    .RD_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .busy(busy),
    .done(done),
    .m0(m0),
    .m11(m11),
    .m12(m12),
    .m13(m13),
    .m14(m14),
    .m21(m21),
    .m22(m22),
    .m23(m23),
    .m24(m24),
    .bypass_en(bypass_en),
    .wr_en(wr_en),
    .addr_read(addr_read),
    .addr_write(addr_write),
    .tw_addr(tw_addr),
    .stage(stage)
`ifdef RFFT_CTRL_READOUT_EN
    ,
    .out_valid(out_valid),
    .out_index(out_index)
`endif
  );

  typedef struct {
    logic        start;
    logic        in_valid;
    logic        ready;
    logic        busy;
    logic        wr;
    logic        m0;
    logic [11:0] aw;
  } vec_t;

  vec_t tv[23];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      @(negedge clk);
      start    = tv[r].start;
      in_valid = tv[r].in_valid;
      #1;
      chk($sformatf("ld%0d_ready", r), in_ready, tv[r].ready);
      chk($sformatf("ld%0d_busy", r), busy, tv[r].busy);
      chk($sformatf("ld%0d_wr", r), wr_en, tv[r].wr);
      chk($sformatf("ld%0d_m0", r), m0, tv[r].m0);
      chk($sformatf("ld%0d_aw", r), addr_write, tv[r].aw);
    end
  endtask

  // c counts cycles from COMPUTE entry; stage s occupies 9 cycles (8 issue + 1 drain).
  task automatic run_compute(input bit start_at_done);
    int got;
    int s, j, kd;
    got = -1;
    for (int c = 0; c < DONE_AT + 10 && got < 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = start_at_done && (c == DONE_AT);
      #1;
      s = c / SPAN;
      j = c % SPAN;
      if (done) begin
        got = c;
        chk("done_busy", busy, 0);
      end else begin
        chk($sformatf("c%0d_busy", c), busy, 1);
        chk($sformatf("c%0d_ready", c), in_ready, 0);
        if (c < NS * SPAN) begin
          chk($sformatf("c%0d_wr", c), wr_en, (j >= 1));
          if (j >= 1) begin
            kd = j - 1;
            chk($sformatf("c%0d_aw", c), addr_write, kd * 'h249);
            chk($sformatf("c%0d_m0", c), m0, 1);
            chk($sformatf("c%0d_sel", c), sel, (s % 2) ? 10'h243 : 10'h0B3);
            chk($sformatf("c%0d_byp", c), bypass_en, (((kd << s) & 7) == 0));
          end else begin
            chk($sformatf("c%0d_byp", c), bypass_en, 0);
          end
          if (j < 8) begin
            chk($sformatf("c%0d_ar", c), addr_read, j * 'h249);
            chk($sformatf("c%0d_tw", c), tw_addr, (j << s) & 7);
            chk($sformatf("c%0d_stage", c), stage, s);
          end
        end
`ifdef RFFT_CTRL_READOUT_EN
        else begin
          j = c - NS * SPAN;
          chk($sformatf("ro%0d_wr", j), wr_en, 0);
          if (j < 8) chk($sformatf("ro%0d_ar", j), addr_read, j * 'h249);
          chk($sformatf("ro%0d_ov", j), out_valid, (j >= 1));
          if (j >= 1) chk($sformatf("ro%0d_oi", j), out_index, j - 1);
        end
`endif
      end
    end
    chk("done_cycle", got, DONE_AT);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++)
      tv[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'(i * 'h249)};
    for (int i = 0; i < 15; i++)
      tv[8+i] = '{1'b0, (i % 2 == 0), 1'b1, 1'b1, (i % 2 == 0), 1'b0,
                  12'((i / 2) * 'h249)};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_outs", outs, 0);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("idle_outs", outs, 0);
    end

    // Frame 1: back-to-back load
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("start_busy0", busy, 0);
    apply_rows(0, 7);
    run_compute(1'b0);
    @(negedge clk);
    #1;
    chk("done_pulse_end", done, 0);
    chk("idle_busy", busy, 0);

    // Frame 2: gapped load, start raised during DONE must be ignored
    @(negedge clk);
    start = 1'b1;
    #1;
    apply_rows(8, 22);
    run_compute(1'b1);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("done_start_busy", busy, 0);
    chk("done_start_ready", in_ready, 0);
    @(negedge clk);
    #1;
    chk("done_start_ignored", busy, 0);

    // Frame 3: abort in stage 1
    @(negedge clk);
    start = 1'b1;
    #1;
    apply_rows(0, 7);
    repeat (13) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_stage", stage, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_outs", outs, 0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done || busy) n++;
    end
    chk("abort_quiet", n, 0);

    // Frame 4: full frame after abort
    @(negedge clk);
    start = 1'b1;
    #1;
    apply_rows(0, 7);
    run_compute(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
